// File: rtl/msp430_instr_enc.sv
// MSP430 instruction encoder: turns one instruction request into a stream of
// 16-bit words (opword, then optional source and destination extension words)
// delivered over a valid/ready handshake.
// Optional feature: define MSP430_ENC_CG_EN to substitute constant-generator
// encodings (R2/R3 modes) for common immediates, dropping their extension word.
module msp430_instr_enc (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  fmt,
  input  logic [3:0]  opcode,
  input  logic [2:0]  op2,
  input  logic [2:0]  jcond,
  input  logic [9:0]  jofs,
  input  logic [3:0]  src_reg,
  input  logic [3:0]  dst_reg,
  input  logic [1:0]  as,
  input  logic        ad,
  input  logic        bw,
  input  logic [15:0] src_ext,
  input  logic [15:0] dst_ext,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [15:0] word_out,
  output logic [1:0]  word_kind,
  output logic        word_last,
  output logic        err,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {IDLE, OPW, SRCX, DSTX} state_t;

  state_t      state;
  logic [15:0] src_ext_q;
  logic [15:0] dst_ext_q;
  logic        need_src_q;
  logic        need_dst_q;

  logic [3:0]  eff_src;
  logic [1:0]  eff_as;
  logic        need_src;
  logic        need_dst;
  logic [15:0] opword;
  logic        handshake;

  assign handshake = word_valid && word_ready;

  // Decode the live request into its opword and extension-word needs; the
  // constant generator may rewrite the source register/mode before encoding.
  always_comb begin
    eff_src  = src_reg;
    eff_as   = as;
    need_src = 1'b0;
    need_dst = 1'b0;
    opword   = 16'h0000;
`ifdef MSP430_ENC_CG_EN
    if (src_reg == 4'd0 && as == 2'b11) begin
      case (src_ext)
        16'h0000: begin eff_src = 4'd3; eff_as = 2'b00; end
        16'h0001: begin eff_src = 4'd3; eff_as = 2'b01; end
        16'h0002: begin eff_src = 4'd3; eff_as = 2'b10; end
        16'hFFFF: begin eff_src = 4'd3; eff_as = 2'b11; end
        16'h0004: begin eff_src = 4'd2; eff_as = 2'b10; end
        16'h0008: begin eff_src = 4'd2; eff_as = 2'b11; end
        default: begin end
      endcase
    end
`endif
    case (fmt)
      2'd1: begin
        opword   = {opcode, eff_src, ad, bw, eff_as, dst_reg};
        need_src = ((eff_as == 2'b01) && (eff_src != 4'd3)) ||
                   ((eff_as == 2'b11) && (eff_src == 4'd0));
        need_dst = ad;
      end
      2'd2: begin
        opword   = {6'b000100, op2, bw, eff_as, eff_src};
        need_src = ((eff_as == 2'b01) && (eff_src != 4'd3)) ||
                   ((eff_as == 2'b11) && (eff_src == 4'd0));
      end
      2'd3: begin
        opword = {3'b001, jcond, jofs};
      end
      default: begin end
    endcase
  end

  // Request acceptance, word sequencing and completion counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      word_valid  <= 1'b0;
      word_out    <= 16'h0000;
      word_kind   <= 2'd0;
      word_last   <= 1'b0;
      err         <= 1'b0;
      instr_count <= 16'h0000;
      src_ext_q   <= 16'h0000;
      dst_ext_q   <= 16'h0000;
      need_src_q  <= 1'b0;
      need_dst_q  <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            if (fmt == 2'd0) begin
              err <= 1'b1;
            end else begin
              src_ext_q  <= src_ext;
              dst_ext_q  <= dst_ext;
              need_src_q <= need_src;
              need_dst_q <= need_dst;
              word_valid <= 1'b1;
              word_out   <= opword;
              word_kind  <= 2'd0;
              word_last  <= !(need_src || need_dst);
              req_ready  <= 1'b0;
              state      <= OPW;
            end
          end
        end
        OPW: begin
          if (handshake) begin
            if (need_src_q) begin
              word_out  <= src_ext_q;
              word_kind <= 2'd1;
              word_last <= !need_dst_q;
              state     <= SRCX;
            end else if (need_dst_q) begin
              word_out  <= dst_ext_q;
              word_kind <= 2'd2;
              word_last <= 1'b1;
              state     <= DSTX;
            end else begin
              word_valid  <= 1'b0;
              word_last   <= 1'b0;
              req_ready   <= 1'b1;
              instr_count <= instr_count + 16'd1;
              state       <= IDLE;
            end
          end
        end
        SRCX: begin
          if (handshake) begin
            if (need_dst_q) begin
              word_out  <= dst_ext_q;
              word_kind <= 2'd2;
              word_last <= 1'b1;
              state     <= DSTX;
            end else begin
              word_valid  <= 1'b0;
              word_last   <= 1'b0;
              req_ready   <= 1'b1;
              instr_count <= instr_count + 16'd1;
              state       <= IDLE;
            end
          end
        end
        DSTX: begin
          if (handshake) begin
            word_valid  <= 1'b0;
            word_last   <= 1'b0;
            req_ready   <= 1'b1;
            instr_count <= instr_count + 16'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
